// File: rtl/sfifo_pkg.sv
// Shared definitions for the 64x8 sfifo and its read-side drain controller.
package sfifo_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } drain_state_e;

endpackage

// File: rtl/sfifo_drain_skid.sv
// Small synchronous FIFO that catches words returning from the sfifo read pipe.
// The head word is held in a register so downstream sees a flop-driven m_data.
module sfifo_drain_skid
  import sfifo_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DataW-1:0]         din,
  input  logic                     pop,
  output logic [DataW-1:0]         head,
  output logic [$clog2(Depth):0]   occ,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [DataW-1:0] head_q, head_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign occ     = wptr_q - rptr_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = head_q;

  always_comb begin
    wptr_d = wptr_q + PtrW'(do_push);
    rptr_d = rptr_q + PtrW'(do_pop);
    head_d = head_q;
    if (rptr_d != wptr_d) begin
      // Once every stored word is consumed, the new head is the word arriving now.
      if (rptr_d == wptr_q) begin
        head_d = din;
      end else begin
        head_d = mem_q[rptr_d[AddrW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AddrW-1:0]] <= din;
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/sfifo_drain.sv
// Read-side controller for the sfifo: issues pops, tracks the read latency pipe,
// buffers returned words in a skid FIFO and streams them out on valid/ready.
module sfifo_drain
  import sfifo_pkg::*;
#(
  parameter int unsigned DataW     = DATA_W,
  parameter int unsigned CntW      = CNT_W,
  parameter int unsigned RdLat     = 2,
  parameter int unsigned SkidDepth = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CntW-1:0]   fifo_count,
  input  logic [DataW-1:0]  fifo_dout,
  input  logic              fifo_uflow,
  output logic              rd_en,
  output logic              m_valid,
  output logic [DataW-1:0]  m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_uflow,
  output logic [15:0]       words_out
);

  localparam int unsigned IflW = $clog2(RdLat + 1);
  localparam int unsigned OccW = $clog2(SkidDepth) + 1;
  localparam int unsigned SumW = OccW + 1;
  localparam int unsigned CmpW = CntW + 1;

  drain_state_e     state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic [RdLat-1:0] vpipe_q, vpipe_d;
  logic             err_q;
  logic [15:0]      words_q;

  logic [IflW-1:0]  inflight;
  logic [OccW-1:0]  skid_occ;
  logic             skid_empty;
  logic             xfer;
  logic             count_ok;
  logic             skid_ok;

  assign m_valid   = !skid_empty;
  assign xfer      = m_valid && m_ready;
  assign rd_en     = rd_en_q;
  assign busy      = (state_q != StIdle) || m_valid;
  assign err_uflow = err_q;
  assign words_out = words_q;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RdLat; i++) begin
      inflight = inflight + IflW'(vpipe_q[i]);
    end
    vpipe_d    = '0;
    vpipe_d[0] = rd_en_q;
    for (int unsigned i = 1; i < RdLat; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  // Count the pending pop as well, so no FIFO count convention can let us pop empty.
  assign count_ok = {1'b0, fifo_count} > (CmpW'(inflight) + CmpW'(rd_en_q));

  // A skid word handed downstream this cycle frees its slot for the new pop.
  assign skid_ok = (SumW'(skid_occ) + SumW'(inflight) + SumW'(rd_en_q)) <
                   (SumW'(SkidDepth) + SumW'(xfer));

  always_comb begin
    rd_en_d = (state_q == StRun) && count_ok && skid_ok;
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if ((inflight == '0) && !rd_en_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rd_en_q <= 1'b0;
      vpipe_q <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      vpipe_q <= vpipe_d;
      if (fifo_uflow && (state_q != StIdle)) begin
        err_q <= 1'b1;
      end
      if (xfer) begin
        words_q <= words_q + 16'd1;
      end
    end
  end

  sfifo_drain_skid #(
    .DataW (DataW),
    .Depth (SkidDepth)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (vpipe_q[RdLat-1]),
    .din   (fifo_dout),
    .pop   (xfer),
    .head  (m_data),
    .occ   (skid_occ),
    .empty (skid_empty)
  );

endmodule

// File: tb/tb_sfifo_drain.sv
// Directed bench for sfifo_drain with a behavioural 64x8 sfifo (2-cycle read latency).
module tb_sfifo_drain;
  import sfifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_uflow = 1'b0;
  logic [6:0]  fifo_count;
  logic [7:0]  fifo_dout;
  logic        rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        busy;
  logic        err_uflow;
  logic [15:0] words_out;

  always #5 clk = ~clk;

  // Behavioural sfifo: pop sampled at the edge, data on dout two cycles after rd_en.
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       mclr = 1'b0;
  logic [7:0] mmem [64];
  logic [5:0] mwp = 6'd0;
  logic [5:0] mrp = 6'd0;
  logic [6:0] mcnt = 7'd0;
  logic [7:0] mstage = 8'h00;
  logic [7:0] mdout = 8'h00;
  logic       m_do_rd;
  logic       m_do_wr;

  assign m_do_rd    = rd_en && (mcnt != 7'd0);
  assign m_do_wr    = wr && (mcnt != 7'd64);
  assign fifo_count = mcnt;
  assign fifo_dout  = mdout;

  always @(posedge clk) begin
    mstage <= mmem[mrp];
    mdout  <= mstage;
    if (mclr) begin
      mwp  <= 6'd0;
      mrp  <= 6'd0;
      mcnt <= 7'd0;
    end else begin
      if (m_do_wr) begin
        mmem[mwp] <= wdata;
        mwp       <= mwp + 6'd1;
      end
      if (m_do_rd) begin
        mrp <= mrp + 6'd1;
      end
      mcnt <= mcnt + 7'(m_do_wr) - 7'(m_do_rd);
    end
  end

  sfifo_drain dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_count (fifo_count),
    .fifo_dout  (fifo_dout),
    .fifo_uflow (fifo_uflow),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .err_uflow  (err_uflow),
    .words_out  (words_out)
  );

  int         checks = 0;
  int         errors = 0;
  int         xfers = 0;
  int         rdens = 0;
  int         uflow_hits = 0;
  int         wseq = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: monitor at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [31:0] exp;
    @(negedge clk);
    if (!rst && m_valid && m_ready) begin
      xfers++;
      exp = 32'hFFFF_FFFF;
      if (exp_q.size() != 0) exp = 32'(exp_q.pop_front());
      check("data_order", 32'(m_data), exp);
    end
    if (rd_en) begin
      rdens++;
      if (mcnt == 7'd0) uflow_hits++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input bit want);
    wr = want && (mcnt != 7'd64);
    if (wr) begin
      wdata = wseq[7:0];
      exp_q.push_back(wdata);
      wseq++;
    end
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      drive_wr(1'b1);
      tick();
    end
    drive_wr(1'b0);
  endtask

  task automatic clear_fifo();
    mclr = 1'b1;
    tick();
    mclr = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    check(tag, 32'(busy), 32'd0);
  endtask

  int r0, x0, xa, xb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_words", 32'(words_out), 32'd0);
    check("rst_err", 32'(err_uflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // 1: 64 preloaded words drain in order at full rate.
    preload(64);
    r0 = rdens;
    x0 = xfers;
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 400 && (xfers - x0) < 64; i++) tick();
    repeat (4) tick();
    check("t1_xfers", 32'(xfers - x0), 32'd64);
    check("t1_pops", 32'(rdens - r0), 32'd64);
    check("t1_words", 32'(words_out), 32'd64);
    check("t1_err", 32'(err_uflow), 32'd0);
    check("t1_no_uflow", 32'(uflow_hits), 32'd0);
    check("t1_m_valid", 32'(m_valid), 32'd0);
    en = 1'b0;
    wait_idle("t1_idle");

    // 2: downstream stalled, only SkidDepth pops go out, head holds.
    m_ready = 1'b0;
    preload(10);
    r0 = rdens;
    x0 = xfers;
    en = 1'b1;
    repeat (20) tick();
    check("t2_pops_stalled", 32'(rdens - r0), 32'd4);
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_head", 32'(m_data), 32'h40);
    repeat (5) tick();
    check("t2_head_hold", 32'(m_data), 32'h40);
    m_ready = 1'b1;
    for (int i = 0; i < 100 && (xfers - x0) < 10; i++) tick();
    check("t2_xfers", 32'(xfers - x0), 32'd10);
    check("t2_pops", 32'(rdens - r0), 32'd10);
    check("t2_words", 32'(words_out), 32'd74);
    check("t2_fifo_empty", 32'(mcnt), 32'd0);
    en = 1'b0;
    wait_idle("t2_idle");

    // 3: en drops with 3 pops committed; only those 3 words come out.
    preload(10);
    r0 = rdens;
    x0 = xfers;
    en = 1'b1;
    for (int i = 0; i < 20 && (rdens - r0 + int'(rd_en)) < 2; i++) tick();
    en = 1'b0;
    tick();
    check("t3_busy_drain", 32'(busy), 32'd1);
    wait_idle("t3_idle");
    check("t3_pops", 32'(rdens - r0), 32'd3);
    check("t3_xfers", 32'(xfers - x0), 32'd3);
    check("t3_words", 32'(words_out), 32'd77);
    clear_fifo();

    // 4: concurrent writes at 1/cycle give a sustained 1 word/cycle.
    x0 = xfers;
    xa = 0;
    xb = 0;
    en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive_wr(c < 40);
      tick();
      if (c == 15) xa = xfers;
      if (c == 35) xb = xfers;
    end
    drive_wr(1'b0);
    for (int i = 0; i < 50 && (xfers - x0) < 40; i++) tick();
    check("t4_rate", 32'(xb - xa), 32'd20);
    check("t4_xfers", 32'(xfers - x0), 32'd40);
    check("t4_no_uflow", 32'(uflow_hits), 32'd0);
    en = 1'b0;
    wait_idle("t4_idle");

    // 5: async reset with words in flight and in the skid.
    m_ready = 1'b0;
    preload(10);
    r0 = rdens;
    en = 1'b1;
    for (int i = 0; i < 20 && (rdens - r0) < 4; i++) tick();
    check("t5_pre_valid", 32'(m_valid), 32'd1);
    check("t5_pre_words", 32'(words_out), 32'd117);
    rst = 1'b1;
    #1;
    check("t5_rd_en", 32'(rd_en), 32'd0);
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_m_data", 32'(m_data), 32'd0);
    check("t5_words", 32'(words_out), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    clear_fifo();
    repeat (5) tick();
    check("t5_ignored", 32'(m_valid), 32'd0);
    check("t5_words_after", 32'(words_out), 32'd0);

    // 6: underflow flag only counts outside IDLE and is sticky; words_out wraps.
    fifo_uflow = 1'b1;
    tick();
    fifo_uflow = 1'b0;
    check("t6_idle_uflow", 32'(err_uflow), 32'd0);
    en = 1'b1;
    tick();
    fifo_uflow = 1'b1;
    tick();
    fifo_uflow = 1'b0;
    check("t6_err_set", 32'(err_uflow), 32'd1);
    repeat (3) tick();
    check("t6_err_sticky", 32'(err_uflow), 32'd1);
    m_ready = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 70000 && (xfers - x0) < 65535; i++) begin
      drive_wr(1'b1);
      tick();
    end
    m_ready = 1'b0;
    drive_wr(1'b0);
    check("t6_words_max", 32'(words_out), 32'h0000_FFFF);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t6_words_wrap", 32'(words_out), 32'd0);
    check("t6_xfers", 32'(xfers - x0), 32'd65536);
    check("t6_err_still", 32'(err_uflow), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_err_rst", 32'(err_uflow), 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
